memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 26 ++
 rtl/memory_stage_data_memory.sv | 47 ++++
 rtl/memory_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared MIPS definitions for the memory stage: memory geometry defaults and
// the EX/MEM and MEM/WB control-flag bundles.
package memory_stage_pkg;

  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned MEM_ADDR_W = 10;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } mem_wb_ctrl_t;

  // True when a byte address is not on a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return |byte_lsb;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Word-addressed data memory: one synchronous write port, one synchronous read
// port with a registered output that returns pre-write contents on collision.
module data_memory
  import memory_stage_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Storage has no reset so contents survive it; the caller gates we with reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: branch resolution, data memory access and MEM/WB register.
// Optional alignment checking with addrError output when MEM_ALIGN_CHECK_EN is defined.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned ADDR_W = MEM_ADDR_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  inPC,
  input  logic        zero,
  input  logic [31:0] aluResult,
  input  logic [31:0] inData2,
  input  logic [4:0]  wr,
  input  logic        inBranch,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic        inMemToReg,
  input  logic        inRegWrite,
  output logic        pcSrc,
  output logic [9:0]  branchTarget,
  output logic [31:0] readData,
  output logic [31:0] outAluResult,
  output logic [4:0]  outWr,
  output logic        outMemToReg,
  output logic        outRegWrite
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        addrError
`endif
);

  ex_mem_ctrl_t      ex_ctrl;
  mem_wb_ctrl_t      wb_ctrl_d, wb_ctrl_q;
  logic [31:0]       alu_result_d, alu_result_q;
  logic [4:0]        wr_d, wr_q;
  logic [ADDR_W-1:0] word_idx;
  logic              access_bad;
  logic              mem_we;
  logic              mem_re;

  assign ex_ctrl = '{
    branch:     inBranch,
    mem_read:   inMemRead,
    mem_write:  inMemWrite,
    mem_to_reg: inMemToReg,
    reg_write:  inRegWrite
  };

  assign pcSrc        = ex_ctrl.branch & zero;
  assign branchTarget = inPC;

  // Upper address bits are dropped so the index wraps modulo DEPTH words.
  assign word_idx = aluResult[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic addr_err_d, addr_err_q;
  logic unused_addr_bits;

  assign unused_addr_bits = ^aluResult[31:ADDR_W+2];
  assign access_bad = (ex_ctrl.mem_read | ex_ctrl.mem_write) & is_misaligned(aluResult[1:0]);

  always_comb begin
    addr_err_d = addr_err_q | access_bad;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addrError = addr_err_q;
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{aluResult[31:ADDR_W+2], aluResult[1:0]};
  assign access_bad       = 1'b0;
`endif

  // Write enable is qualified by reset so a store at a reset-asserted edge is lost.
  assign mem_we = ex_ctrl.mem_write & reset & ~access_bad;
  assign mem_re = ex_ctrl.mem_read & ~access_bad;

  data_memory #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_memory (
    .clk   (clock),
    .rst_n (reset),
    .we    (mem_we),
    .waddr (word_idx),
    .wdata (inData2),
    .re    (mem_re),
    .raddr (word_idx),
    .rdata (readData)
  );

  always_comb begin
    wb_ctrl_d    = '{mem_to_reg: ex_ctrl.mem_to_reg, reg_write: ex_ctrl.reg_write};
    alu_result_d = aluResult;
    wr_d         = wr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_ctrl_q    <= '0;
      alu_result_q <= '0;
      wr_q         <= '0;
    end else begin
      wb_ctrl_q    <= wb_ctrl_d;
      alu_result_q <= alu_result_d;
      wr_q         <= wr_d;
    end
  end

  assign outAluResult = alu_result_q;
  assign outWr        = wr_q;
  assign outMemToReg  = wb_ctrl_q.mem_to_reg;
  assign outRegWrite  = wb_ctrl_q.reg_write;

endmodule
